dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single data memory port (byte-enabled, synchronous-read, one-cycle read latency) between two requesters: the pipeline MEM stage (cpu) and the debug/program loader (dbg).
- Grants one access per cycle and drives the memory's addr/in/MemLen/MemRead/MemWrite/CE.
- Routes the registered read data back to the requester that issued the read.
- Adds misalignment checking, starvation protection for dbg, and a dbg bus-lock mode for burst loads.

Parameters:
- WIDTH, 32, memory size in bytes; ADDR_W = $clog2(WIDTH) is derived.
- DEPTH, 8, data width is 4*DEPTH bits (32).
- MAX_WAIT, 4, number of consecutive denied dbg cycles before dbg is forced a grant; range 1..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- cpu_req  in  1  cpu access request, valid for the current cycle.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_len  in  3  MemLen encoding: 001 = byte unsigned, 010 = half unsigned, 101 = byte signed, 110 = half signed, other values = word.
- cpu_addr  in  ADDR_W  byte address.
- cpu_wdata  in  4*DEPTH  store data, right-aligned.
- cpu_gnt  out  1  access accepted this cycle (combinational).
- cpu_stall  out  1  cpu_req & ~cpu_gnt.
- cpu_rvalid  out  1  load data valid, one cycle after the granted load.
- cpu_rdata  out  4*DEPTH  load data.
- cpu_err  out  1  misaligned-access pulse, one cycle after the grant.
- dbg_req, dbg_we, dbg_len, dbg_addr, dbg_wdata  in  same widths as cpu_*  debug requester.
- dbg_lock  in  1  hold exclusive ownership while asserted.
- dbg_gnt, dbg_rvalid, dbg_rdata, dbg_err  out  same widths as cpu_*  debug responses.
- mem_addr  out  ADDR_W  to memory addr.
- mem_in  out  4*DEPTH  to memory in.
- mem_len  out  3  to memory MemLen.
- mem_read  out  1  to memory MemRead.
- mem_write  out  1  to memory MemWrite.
- mem_ce  out  1  to memory CE.
- mem_out  in  4*DEPTH  memory read data, valid the cycle after the read.

Behaviour:
- Reset:
  - Asynchronous, active-high. Clears state to ARB, starve_cnt = 0, rd_pend = 0, and both err flags.
  - While rst = 1, all outputs are 0, including gnt and mem_* (combinational outputs are gated by rst).
  - A read in flight when reset asserts is discarded; no rvalid follows.
- State machine, two states:
  - ARB: fixed priority to cpu, except that dbg wins when starve_cnt == MAX_WAIT.
  - ARB -> LOCK when dbg is granted with dbg_lock = 1.
  - LOCK: cpu_gnt = 0. dbg_gnt = dbg_req. Stays in LOCK while dbg_lock = 1.
  - LOCK -> ARB on the first edge with dbg_lock = 0. The cycle in which dbg_lock = 0 is already arbitrated as ARB.
- starve_cnt:
  - Increments, saturating at MAX_WAIT, on each edge with dbg_req & ~dbg_gnt.
  - Clears to 0 on any dbg grant.
  - Holds when dbg_req = 0.
- Grant cycle:
  - Drive mem_addr, mem_in and mem_len from the winner.
  - mem_read = ~we; mem_write = we; mem_ce = 1.
  - No grant: mem_ce = mem_read = mem_write = 0. mem_addr, mem_in and mem_len are 0.
- Misalignment:
  - Half access (len[1:0] = 10) with addr[0] = 1 is misaligned.
  - Word access (len[1:0] = 00 or 11) with addr[1:0] != 00 is misaligned.
  - A misaligned access is still granted, to consume the request, but mem_ce, mem_read and mem_write are forced to 0.
  - The owner's err is 1 for exactly the next cycle. No rvalid is generated.
- Read return:
  - A granted aligned load registers rd_pend = 1 and rd_owner.
  - In the next cycle, the owner's rvalid = 1 and rdata = mem_out. The non-owner's rdata = 0. rdata = 0 whenever rvalid = 0.
  - Back-to-back loads from either requester are allowed every cycle: rd_pend and rd_owner are reloaded on each edge.
- Stores: no response beyond gnt. A store and a load to the same address in consecutive cycles return the new data, relying on the memory's write-first behaviour.
- No internal queue: a denied requester must hold req and its operands stable until gnt.

Test Plan:
- cpu only: cpu_req = 1, we = 1, len = 000, addr = 0x08, wdata = 0xDEADBEEF; then a load from 0x08 -> cpu_gnt = 1 both cycles; cpu_rvalid = 1 one cycle after the load; cpu_rdata = 0xDEADBEEF; dbg_* stay 0.
- Contention and starvation, MAX_WAIT = 4: cpu_req and dbg_req both held at 1 -> cpu granted for 4 cycles; dbg granted in the 5th cycle with cpu_stall = 1; cpu granted again in the 6th cycle; starve_cnt = 0 after the dbg grant.
- Lock burst: dbg_lock = 1 with 3 dbg stores to 0x00/0x04/0x08 while cpu_req = 1 -> cpu_stall = 1 throughout; dbg_gnt = 1 for 3 cycles; with dbg_lock = 0 in the 4th cycle, cpu is granted in that cycle.
- Misaligned: cpu load, len = 010, addr = 0x05 -> cpu_gnt = 1, mem_ce = 0; cpu_err = 1 for one cycle; cpu_rvalid stays 0. Repeat with len = 000, addr = 0x06 -> same response.
- Interleaved reads: dbg load 0x0C in cycle n (starve forced), then cpu load 0x10 in cycle n+1 -> dbg_rvalid in n+1 with mem_out; cpu_rvalid in n+2; no cross-delivery of rdata.
- Reset mid-read: cpu load granted, then rst asserted before the next edge -> cpu_rvalid never asserts; all outputs 0; after release, state is ARB and starve_cnt = 0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one synchronous-read data memory port between the
// pipeline MEM stage (cpu) and the debug/program loader (dbg). One access is
// granted per cycle. The cpu has fixed priority, but a starvation counter
// eventually forces a dbg grant. dbg can also lock the bus for burst loads.
// Misaligned accesses are consumed without touching memory and are reported
// on err one cycle later.
module dmem_arbiter #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 8,
  parameter int MAX_WAIT = 4,
  localparam int ADDR_W  = $clog2(WIDTH),
  localparam int DW      = 4 * DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [2:0]        cpu_len,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DW-1:0]     cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DW-1:0]     cpu_rdata,
  output logic              cpu_err,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [2:0]        dbg_len,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DW-1:0]     dbg_wdata,
  input  logic              dbg_lock,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DW-1:0]     dbg_rdata,
  output logic              dbg_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DW-1:0]     mem_in,
  output logic [2:0]        mem_len,
  output logic              mem_read,
  output logic              mem_write,
  output logic              mem_ce,
  input  logic [DW-1:0]     mem_out
);

  typedef enum logic {ARB, LOCK} state_t;

  localparam logic [3:0] MAX_CNT = 4'(MAX_WAIT);

  state_t     state_reg, state_next;
  logic [3:0] starve_cnt_reg;
  logic       rd_pend_reg;
  logic       rd_owner_reg;   // 1 = dbg issued the pending read
  logic       cpu_err_reg, dbg_err_reg;

  logic              cpu_win, dbg_win;
  logic              any_gnt, sel_we, mis;
  logic [ADDR_W-1:0] sel_addr;
  logic [2:0]        sel_len;
  logic [DW-1:0]     sel_wdata;

  // Half accesses need an even address, word accesses need a 4-byte aligned
  // one; byte accesses are always aligned.
  function automatic logic misaligned(input logic [2:0] len,
                                      input logic [ADDR_W-1:0] addr);
    case (len[1:0])
      2'b01:   return 1'b0;
      2'b10:   return addr[0];
      default: return (addr[1:0] != 2'b00);
    endcase
  endfunction

  // State register: owner tracking, starvation counter, read return and err flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= ARB;
      starve_cnt_reg <= '0;
      rd_pend_reg    <= 1'b0;
      rd_owner_reg   <= 1'b0;
      cpu_err_reg    <= 1'b0;
      dbg_err_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      rd_pend_reg  <= any_gnt & ~mis & ~sel_we;
      rd_owner_reg <= dbg_win;
      cpu_err_reg  <= cpu_win & mis;
      dbg_err_reg  <= dbg_win & mis;
      if (dbg_win)
        starve_cnt_reg <= '0;
      else if (dbg_req && starve_cnt_reg != MAX_CNT)
        starve_cnt_reg <= starve_cnt_reg + 4'd1;
    end
  end

  // Arbitration and next state. The cycle in which dbg drops lock is already
  // arbitrated normally, so LOCK only takes effect while dbg_lock is high.
  always_comb begin
    cpu_win    = 1'b0;
    dbg_win    = 1'b0;
    state_next = state_reg;
    if (!rst) begin
      if (state_reg == LOCK && dbg_lock) begin
        dbg_win = dbg_req;
      end else begin
        dbg_win = dbg_req && (!cpu_req || starve_cnt_reg == MAX_CNT);
        cpu_win = cpu_req && !dbg_win;
      end
      case (state_reg)
        ARB:     if (dbg_win && dbg_lock) state_next = LOCK;
        LOCK:    if (!dbg_lock)           state_next = ARB;
        default: state_next = ARB;
      endcase
    end
  end

  // Memory port mux: the winner's operands, all zero when nobody is granted.
  always_comb begin
    any_gnt   = cpu_win | dbg_win;
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_len   = '0;
    sel_wdata = '0;
    if (dbg_win) begin
      sel_we    = dbg_we;
      sel_addr  = dbg_addr;
      sel_len   = dbg_len;
      sel_wdata = dbg_wdata;
    end else if (cpu_win) begin
      sel_we    = cpu_we;
      sel_addr  = cpu_addr;
      sel_len   = cpu_len;
      sel_wdata = cpu_wdata;
    end
    mis = any_gnt & misaligned(sel_len, sel_addr);
  end

  assign cpu_gnt   = cpu_win;
  assign dbg_gnt   = dbg_win;
  assign cpu_stall = ~rst & cpu_req & ~cpu_win;

  assign mem_addr  = sel_addr;
  assign mem_in    = sel_wdata;
  assign mem_len   = sel_len;
  assign mem_ce    = any_gnt & ~mis;
  assign mem_read  = any_gnt & ~mis & ~sel_we;
  assign mem_write = any_gnt & ~mis & sel_we;

  // Read data goes only to the requester that issued the load.
  assign cpu_rvalid = ~rst & rd_pend_reg & ~rd_owner_reg;
  assign dbg_rvalid = ~rst & rd_pend_reg & rd_owner_reg;
  assign cpu_rdata  = cpu_rvalid ? mem_out : '0;
  assign dbg_rdata  = dbg_rvalid ? mem_out : '0;
  assign cpu_err    = ~rst & cpu_err_reg;
  assign dbg_err    = ~rst & dbg_err_reg;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed stimulus for dmem_arbiter. Grant-cycle outputs
// are checked inline; load/err responses are pushed into a scoreboard queue
// and checked by an independent monitor when the DUT presents them.
`timescale 1ns/1ps
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, dbg_req, dbg_we, dbg_lock;
  logic [2:0]  cpu_len, dbg_len;
  logic [4:0]  cpu_addr, dbg_addr;
  logic [31:0] cpu_wdata, dbg_wdata;
  logic        cpu_gnt, cpu_stall, cpu_rvalid, cpu_err;
  logic        dbg_gnt, dbg_rvalid, dbg_err;
  logic [31:0] cpu_rdata, dbg_rdata;
  logic [4:0]  mem_addr;
  logic [31:0] mem_in, mem_out;
  logic [2:0]  mem_len;
  logic        mem_read, mem_write, mem_ce;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    bit          is_dbg;
    bit          is_err;
    logic [31:0] data;
  } exp_t;
  exp_t sb_q[$];

  logic [31:0] mem [8];

  dmem_arbiter #(.WIDTH(32), .DEPTH(8), .MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_len(cpu_len), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall),
    .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_len(dbg_len), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_lock(dbg_lock), .dbg_gnt(dbg_gnt),
    .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata), .dbg_err(dbg_err),
    .mem_addr(mem_addr), .mem_in(mem_in), .mem_len(mem_len),
    .mem_read(mem_read), .mem_write(mem_write), .mem_ce(mem_ce),
    .mem_out(mem_out)
  );

  always #5 clk = ~clk;

  // Word-wide memory model with one-cycle registered read.
  always @(posedge clk) begin
    if (mem_ce && mem_write) mem[mem_addr[4:2]] <= mem_in;
    if (mem_ce && mem_read)  mem_out <= mem[mem_addr[4:2]];
  end

  task automatic chk(input string tag, input string what,
                     input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s.%s got=0x%08h want=0x%08h @%0t", tag, what, act, exp, $time);
    end
  endtask

  task automatic set_cpu(input logic req, input logic we, input logic [2:0] len,
                         input logic [4:0] addr, input logic [31:0] wd);
    cpu_req = req; cpu_we = we; cpu_len = len; cpu_addr = addr; cpu_wdata = wd;
  endtask

  task automatic set_dbg(input logic req, input logic we, input logic [2:0] len,
                         input logic [4:0] addr, input logic [31:0] wd, input logic lock);
    dbg_req = req; dbg_we = we; dbg_len = len; dbg_addr = addr; dbg_wdata = wd;
    dbg_lock = lock;
  endtask

  // One cycle: check grant-cycle outputs against the expected winner, queue
  // the expected response (rk: 0 none, 1 read data, 2 err), advance.
  task automatic tick(input bit eg_c, input bit eg_d, input bit e_ce, input int rk,
                      input bit r_dbg, input logic [31:0] r_data, input string tag);
    logic [4:0]  e_addr;
    logic [31:0] e_wd;
    logic [2:0]  e_len;
    logic        e_we;
    exp_t        e;
    e_addr = eg_c ? cpu_addr  : eg_d ? dbg_addr  : 5'd0;
    e_wd   = eg_c ? cpu_wdata : eg_d ? dbg_wdata : 32'd0;
    e_len  = eg_c ? cpu_len   : eg_d ? dbg_len   : 3'd0;
    e_we   = eg_c ? cpu_we    : dbg_we;
    @(negedge clk);
    chk(tag, "cpu_gnt",   32'(cpu_gnt),   32'(eg_c));
    chk(tag, "dbg_gnt",   32'(dbg_gnt),   32'(eg_d));
    chk(tag, "cpu_stall", 32'(cpu_stall), 32'(cpu_req & ~eg_c));
    chk(tag, "mem_ce",    32'(mem_ce),    32'(e_ce));
    chk(tag, "mem_write", 32'(mem_write), 32'(e_ce & e_we));
    chk(tag, "mem_read",  32'(mem_read),  32'(e_ce & ~e_we));
    chk(tag, "mem_addr",  32'(mem_addr),  32'(e_addr));
    chk(tag, "mem_in",    mem_in,         e_wd);
    chk(tag, "mem_len",   32'(mem_len),   32'(e_len));
    if (rk != 0) begin
      e.is_dbg = r_dbg;
      e.is_err = (rk == 2);
      e.data   = (rk == 2) ? 32'd0 : r_data;
      sb_q.push_back(e);
    end
    $display("txn %-10s cpu_gnt=%0b dbg_gnt=%0b ce=%0b addr=0x%02h", tag,
             cpu_gnt, dbg_gnt, mem_ce, mem_addr);
    @(posedge clk);
    #1;
  endtask

  // Response monitor: any rvalid/err pops the next expected response.
  always @(negedge clk) begin
    exp_t e;
    if (cpu_rvalid || cpu_err || dbg_rvalid || dbg_err) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL mon.spurious got cpu_rv=%0b cpu_err=%0b dbg_rv=%0b dbg_err=%0b want none @%0t",
                 cpu_rvalid, cpu_err, dbg_rvalid, dbg_err, $time);
      end else begin
        e = sb_q.pop_front();
        chk("mon", "owner_dbg", 32'(dbg_rvalid | dbg_err), 32'(e.is_dbg));
        chk("mon", "is_err",    32'(cpu_err | dbg_err),    32'(e.is_err));
        chk("mon", "rdata",       e.is_dbg ? dbg_rdata : cpu_rdata, e.data);
        chk("mon", "other_rdata", e.is_dbg ? cpu_rdata : dbg_rdata, 32'd0);
        $display("rsp dbg=%0b err=%0b data=0x%08h", e.is_dbg, e.is_err, e.data);
      end
    end
  end

  function automatic logic any_out();
    return |{cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata, cpu_err,
             dbg_gnt, dbg_rvalid, dbg_rdata, dbg_err,
             mem_addr, mem_in, mem_len, mem_read, mem_write, mem_ce};
  endfunction

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 32'd0;
    mem_out = 32'd0;
    rst = 1'b1;
    set_cpu(0, 0, 3'b000, 5'h00, 32'd0);
    set_dbg(0, 0, 3'b000, 5'h00, 32'd0, 0);
    repeat (2) @(negedge clk);
    chk("reset", "all_out", 32'(any_out()), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // cpu only: store then load back
    set_cpu(1, 1, 3'b000, 5'h08, 32'hDEADBEEF);
    tick(1, 0, 1, 0, 0, 0, "cpu_st");
    set_cpu(1, 0, 3'b000, 5'h08, 32'd0);
    tick(1, 0, 1, 1, 0, 32'hDEADBEEF, "cpu_ld");
    set_cpu(1, 1, 3'b000, 5'h0C, 32'hC0C0C0C0);
    tick(1, 0, 1, 0, 0, 0, "cpu_st");
    set_cpu(1, 1, 3'b000, 5'h10, 32'h10101010);
    tick(1, 0, 1, 0, 0, 0, "cpu_st");

    // contention: 4 cpu grants then a forced dbg grant, twice over
    set_cpu(1, 1, 3'b000, 5'h14, 32'h14141414);
    set_dbg(1, 1, 3'b000, 5'h18, 32'h18181818, 0);
    for (int r = 0; r < 2; r++) begin
      repeat (4) tick(1, 0, 1, 0, 0, 0, "contend");
      tick(0, 1, 1, 0, 0, 0, "starve");
    end
    tick(1, 0, 1, 0, 0, 0, "contend");

    // lock burst: starvation wins the first locked store, rest stay locked
    repeat (3) tick(1, 0, 1, 0, 0, 0, "pre_lock");
    set_dbg(1, 1, 3'b000, 5'h00, 32'hA0A0A0A0, 1);
    tick(0, 1, 1, 0, 0, 0, "lock0");
    set_dbg(1, 1, 3'b000, 5'h04, 32'hA4A4A4A4, 1);
    tick(0, 1, 1, 0, 0, 0, "lock1");
    set_dbg(0, 0, 3'b000, 5'h00, 32'd0, 1);
    tick(0, 0, 0, 0, 0, 0, "lock_idle");
    set_dbg(1, 1, 3'b000, 5'h08, 32'hA8A8A8A8, 1);
    tick(0, 1, 1, 0, 0, 0, "lock2");
    set_dbg(0, 0, 3'b000, 5'h00, 32'd0, 0);
    tick(1, 0, 1, 0, 0, 0, "unlock");
    set_cpu(1, 0, 3'b000, 5'h08, 32'd0);
    tick(1, 0, 1, 1, 0, 32'hA8A8A8A8, "cpu_ld");

    // misaligned half and word loads
    set_cpu(1, 0, 3'b010, 5'h05, 32'd0);
    tick(1, 0, 0, 2, 0, 0, "mis_half");
    set_cpu(1, 0, 3'b000, 5'h06, 32'd0);
    tick(1, 0, 0, 2, 0, 0, "mis_word");
    set_cpu(0, 0, 3'b000, 5'h00, 32'd0);
    tick(0, 0, 0, 0, 0, 0, "idle");

    // interleaved reads: starved dbg load, then cpu load next cycle
    set_cpu(1, 1, 3'b000, 5'h14, 32'h14141414);
    set_dbg(1, 0, 3'b000, 5'h0C, 32'd0, 0);
    repeat (4) tick(1, 0, 1, 0, 0, 0, "il_pre");
    tick(0, 1, 1, 1, 1, 32'hC0C0C0C0, "il_dbg");
    set_dbg(0, 0, 3'b000, 5'h00, 32'd0, 0);
    set_cpu(1, 0, 3'b000, 5'h10, 32'd0);
    tick(1, 0, 1, 1, 0, 32'h10101010, "il_cpu");
    set_cpu(0, 0, 3'b000, 5'h00, 32'd0);
    tick(0, 0, 0, 0, 0, 0, "idle");

    // reset mid-read with starve_cnt built up to 3
    set_cpu(1, 1, 3'b000, 5'h14, 32'h14141414);
    set_dbg(1, 1, 3'b000, 5'h1C, 32'h1C1C1C1C, 1);
    repeat (3) tick(1, 0, 1, 0, 0, 0, "rst_pre");
    set_dbg(0, 0, 3'b000, 5'h00, 32'd0, 0);
    set_cpu(1, 0, 3'b000, 5'h08, 32'd0);
    @(negedge clk);
    chk("rst_ld", "cpu_gnt", 32'(cpu_gnt), 32'd1);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_mid", "all_out", 32'(any_out()), 32'd0);
    set_cpu(0, 0, 3'b000, 5'h00, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    set_cpu(1, 1, 3'b000, 5'h14, 32'h14141414);
    set_dbg(1, 1, 3'b000, 5'h1C, 32'h1C1C1C1C, 1);
    repeat (4) tick(1, 0, 1, 0, 0, 0, "post_rst");
    tick(0, 1, 1, 0, 0, 0, "post_starve");
    set_dbg(0, 0, 3'b000, 5'h00, 32'd0, 0);
    tick(1, 0, 1, 0, 0, 0, "post_unlock");
    set_cpu(0, 0, 3'b000, 5'h00, 32'd0);
    repeat (2) tick(0, 0, 0, 0, 0, 0, "idle");

    chk("sb", "drain", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
